// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared constants for the counter family: direction and limit-mode
//   encodings plus default widths, so sibling counter blocks decode
//   up_dn / sat_mode the same way.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_PRESCALE_W = 4;

endpackage

// File: rtl/updown_counter_n_prescaler_tick.sv
// prescaler_tick
//   Clock-enable prescaler. Produces a one-cycle tick every div+1 enabled
//   cycles.
//   Ports:
//     clk    - clock, rising edge
//     rst_n  - asynchronous active-low reset
//     en     - advance enable; the prescaler is frozen when low
//     clr    - synchronous clear, wins over en (tick suppressed)
//     div    - divide setting, ratio = div+1
//     tick   - high in the cycle a step is to be taken (combinational)
module prescaler_tick #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] pre_cnt;

  // div is compared live: if it drops below pre_cnt, the counter keeps
  // incrementing, wraps through all-ones to 0 and ticks when it next matches.
  assign tick = en && !clr && (pre_cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (clr) begin
      pre_cnt <= '0;
    end else if (en) begin
      if (pre_cnt == div) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/updown_counter_n.sv
// updown_counter_n
//   Loadable up/down counter over the range [0, mod_max] with wrap or
//   saturate at the limits, prescaled stepping and a registered
//   terminal-count pulse. The count drives a shared tri-state bus and is
//   also available as an always-driven copy.
//   Ports:
//     clk, rst_n   - clock (rising edge), asynchronous active-low reset
//     cnt_en       - gates prescaler and counter
//     up_dn        - DIR_UP / DIR_DOWN
//     sat_mode     - MODE_WRAP / MODE_SAT
//     prescale     - step every prescale+1 enabled cycles
//     mod_max      - upper limit of the count range
//     load,load_in - synchronous load (highest priority)
//     out_en       - bus drive enable
//     count_out    - count when out_en=1, high-Z otherwise
//     count_raw    - count register, always driven
//     tc           - one-cycle pulse aligned with the count after a terminal step
module updown_counter_n
  import counter_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cnt_en,
  input  logic                  up_dn,
  input  logic                  sat_mode,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      mod_max,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_in,
  input  logic                  out_en,
  output tri   [WIDTH-1:0]      count_out,
  output logic [WIDTH-1:0]      count_raw,
  output logic                  tc
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic             step;

  prescaler_tick #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .clr   (load),
    .div   (prescale),
    .tick  (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc      <= 1'b0;
    end else if (load) begin
      // Out-of-range load values are kept; the next step pulls them back.
      count_q <= load_in;
      tc      <= 1'b0;
    end else if (step) begin
      if (up_dn == DIR_UP) begin
        // >= also covers a count left above a lowered mod_max.
        if (count_q >= mod_max) begin
          count_q <= (sat_mode == MODE_SAT) ? mod_max : '0;
          tc      <= 1'b1;
        end else begin
          count_q <= count_q + ONE;
          tc      <= 1'b0;
        end
      end else begin
        if (count_q == '0) begin
          count_q <= (sat_mode == MODE_SAT) ? '0 : mod_max;
          tc      <= 1'b1;
        end else if (count_q > mod_max) begin
          // Re-entering the range from above is not a terminal event.
          count_q <= mod_max;
          tc      <= 1'b0;
        end else begin
          count_q <= count_q - ONE;
          tc      <= 1'b0;
        end
      end
    end else begin
      tc <= 1'b0;
    end
  end

  assign count_raw = count_q;
  assign count_out = out_en ? count_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_updown_counter_n.sv
module tb_updown_counter_n;
  import counter_pkg::*;

  localparam int W  = 12;
  localparam int PW = 4;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          cnt_en   = 1'b0;
  logic          up_dn    = DIR_UP;
  logic          sat_mode = MODE_WRAP;
  logic [PW-1:0] prescale = '0;
  logic [W-1:0]  mod_max  = '0;
  logic          load     = 1'b0;
  logic [W-1:0]  load_in  = '0;
  logic          out_en   = 1'b0;

  // Pulled-up bus: an undriven bus reads all-ones.
  tri1 [W-1:0]   count_bus;
  logic [W-1:0]  count_raw;
  logic          tc;

  updown_counter_n #(
    .WIDTH      (W),
    .PRESCALE_W (PW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt_en    (cnt_en),
    .up_dn     (up_dn),
    .sat_mode  (sat_mode),
    .prescale  (prescale),
    .mod_max   (mod_max),
    .load      (load),
    .load_in   (load_in),
    .out_en    (out_en),
    .count_out (count_bus),
    .count_raw (count_raw),
    .tc        (tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] cnt;
    logic         tc;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]  m_cnt = '0;
  logic [PW-1:0] m_pre = '0;
  logic          m_tc  = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour for one rising edge with the inputs currently applied.
  task automatic model_edge();
    logic tick;
    if (load) begin
      m_cnt = load_in;
      m_pre = '0;
      m_tc  = 1'b0;
    end else if (cnt_en) begin
      tick  = (m_pre == prescale);
      m_pre = tick ? '0 : m_pre + 1'b1;
      m_tc  = 1'b0;
      if (tick) begin
        if (up_dn == DIR_UP) begin
          if (m_cnt >= mod_max) begin
            m_cnt = sat_mode ? mod_max : '0;
            m_tc  = 1'b1;
          end else begin
            m_cnt = m_cnt + 1'b1;
          end
        end else begin
          if (m_cnt == 0) begin
            m_cnt = sat_mode ? '0 : mod_max;
            m_tc  = 1'b1;
          end else if (m_cnt > mod_max) begin
            m_cnt = mod_max;
          end else begin
            m_cnt = m_cnt - 1'b1;
          end
        end
      end
    end else begin
      m_tc = 1'b0;
    end
  endtask

  // Called just after a rising edge: predict, advance one clock, compare.
  task automatic cycle(input string tag);
    exp_t e;
    model_edge();
    e.cnt = m_cnt;
    e.tc  = m_tc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, W'(1), W'(0));
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_cnt"}, count_raw, e.cnt);
      chk({tag, "_tc"}, W'(tc), W'(e.tc));
      chk({tag, "_bus"}, count_bus, out_en ? e.cnt : {W{1'b1}});
    end
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_cnt", count_raw, '0);
    chk("rst_tc", W'(tc), '0);
    chk("rst_bus_z", count_bus, {W{1'b1}});
    out_en = 1'b1;
    #1;
    chk("rst_bus_on", count_bus, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Async reset mid-count with tc high
    load = 1'b1; load_in = 12'h037; mod_max = 12'h037;
    cycle("pre_rst_load");
    load = 1'b0; cnt_en = 1'b1; up_dn = DIR_UP; sat_mode = MODE_SAT; prescale = '0;
    cycle("pre_rst_sat");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", count_raw, '0);
    chk("arst_tc", W'(tc), '0);
    chk("arst_bus_on", count_bus, '0);
    out_en = 1'b0;
    #1;
    chk("arst_bus_z", count_bus, {W{1'b1}});
    m_cnt = '0; m_pre = '0; m_tc = 1'b0;
    out_en = 1'b1; cnt_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Up wrap, mod_max=9
    load = 1'b1; load_in = '0; mod_max = 12'd9;
    cycle("wrap_load");
    load = 1'b0; cnt_en = 1'b1; up_dn = DIR_UP; sat_mode = MODE_WRAP; prescale = '0;
    for (int i = 0; i < 12; i++) cycle("up_wrap");

    // Down saturate from 3
    load = 1'b1; load_in = 12'd3; mod_max = 12'd200;
    cycle("sat_load");
    load = 1'b0; up_dn = DIR_DOWN; sat_mode = MODE_SAT;
    for (int i = 0; i < 6; i++) cycle("dn_sat");

    // Prescaler /4 with a 2-cycle enable gap
    load = 1'b1; load_in = '0; mod_max = 12'd100; up_dn = DIR_UP; sat_mode = MODE_WRAP;
    cycle("pre_load");
    load = 1'b0; prescale = 4'd3;
    for (int i = 0; i < 14; i++) begin
      cnt_en = (i == 6 || i == 7) ? 1'b0 : 1'b1;
      cycle("presc");
    end
    chk("presc_final", count_raw, 12'd3);

    // Live prescale lowered below the running prescaler
    cnt_en = 1'b1;
    for (int i = 0; i < 3; i++) cycle("live_a");
    prescale = 4'd1;
    for (int i = 0; i < 18; i++) cycle("live_b");
    prescale = '0;

    // Load priority over a pending step, then up / down from above range
    mod_max = 12'h010; load = 1'b1; load_in = 12'h0F0;
    cycle("ld_prio");
    load = 1'b0; up_dn = DIR_UP;
    cycle("ld_up");
    load = 1'b1;
    cycle("ld_prio2");
    load = 1'b0; up_dn = DIR_DOWN;
    cycle("ld_dn");

    // Full-width wrap
    mod_max = 12'hFFF; load = 1'b1; load_in = 12'hFFE; up_dn = DIR_UP; sat_mode = MODE_WRAP;
    cycle("fw_load");
    load = 1'b0;
    for (int i = 0; i < 3; i++) cycle("fw_up");

    // mod_max = 0, both directions and modes
    mod_max = '0;
    for (int i = 0; i < 8; i++) begin
      up_dn    = i[0];
      sat_mode = i[1];
      cycle("mod0");
    end

    // Saturate up re-asserts tc at the limit
    mod_max = 12'd2; sat_mode = MODE_SAT; up_dn = DIR_UP;
    for (int i = 0; i < 5; i++) cycle("sat_up");

    // Randomised mix
    for (int i = 0; i < 400; i++) begin
      load     = ($urandom_range(0, 15) == 0);
      load_in  = W'($urandom_range(0, 40));
      cnt_en   = ($urandom_range(0, 3) != 0);
      up_dn    = ($urandom_range(0, 3) != 0) ? DIR_UP : DIR_DOWN;
      if ($urandom_range(0, 31) == 0) sat_mode = ~sat_mode;
      if ($urandom_range(0, 31) == 0) mod_max = W'($urandom_range(0, 30));
      if ($urandom_range(0, 31) == 0) prescale = PW'($urandom_range(0, 2));
      out_en   = ($urandom_range(0, 7) != 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
